// File: rtl/ahb_tl_pkg.sv
// Shared constants for the AHB-Lite <-> TL-UL bridges.
package ahb_tl_pkg;

  // TL-UL A/D channel opcodes
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // AHB transfer types and responses
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Bridge FSM encoding
  localparam int unsigned ST_W    = 3;
  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_REQ  = 3'd1;
  localparam logic [2:0]  ST_RESP = 3'd2;
  localparam logic [2:0]  ST_DONE = 3'd3;
  localparam logic [2:0]  ST_ERR1 = 3'd4;
  localparam logic [2:0]  ST_ERR2 = 3'd5;

  // Bytes per data beat
  function automatic int unsigned dbw_f(input int unsigned dw);
    return dw / 32'd8;
  endfunction

  // Width of a TL size field able to hold log2(bytes per beat)
  function automatic int unsigned szw_f(input int unsigned dw);
    return 32'($clog2($clog2(dw / 32'd8) + 1));
  endfunction

endpackage

// File: rtl/ahb_tl_mask_gen.sv
// Byte-lane mask from transfer size and address offset, plus legality flags.
module ahb_tl_mask_gen
  import ahb_tl_pkg::*;
#(
  parameter  int unsigned DBW  = 4,
  localparam int unsigned OFFW = $clog2(DBW)
) (
  input  logic [2:0]      size_i,
  input  logic [OFFW-1:0] offset_i,
  output logic [DBW-1:0]  mask_o,
  output logic            size_ok_o,
  output logic            aligned_o
);

  // Lanes [off, off + 2^size) are enabled; flags say whether the access fits the bus
  always_comb begin
    int unsigned nbytes;
    int unsigned off;
    nbytes    = 32'd1 << size_i;
    off       = 32'(offset_i);
    size_ok_o = (32'(size_i) <= OFFW);
    aligned_o = ((off & (nbytes - 32'd1)) == 32'd0);
    mask_o    = '0;
    for (int unsigned i = 0; i < DBW; i++) begin
      mask_o[i] = (i >= off) && (i < off + nbytes);
    end
  end

endmodule

// File: rtl/ahb_tl_bridge_param.sv
// AHB-Lite subordinate to TL-UL host bridge, one TL transaction outstanding.
module ahb_tl_bridge_param
  import ahb_tl_pkg::*;
#(
  parameter  int unsigned AW        = 32,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned SRCW      = 8,
  parameter  int unsigned SINKW     = 1,
  parameter  int unsigned NM        = 8,
  parameter  bit          POSTED_WR = 1'b0,
  localparam int unsigned DBW       = dbw_f(DW),
  localparam int unsigned SZW       = szw_f(DW)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hsel_i,
  input  logic             hready_i,
  input  logic [1:0]       htrans_i,
  input  logic [AW-1:0]    haddr_i,
  input  logic             hwrite_i,
  input  logic [2:0]       hsize_i,
  input  logic [NM-1:0]    hmaster_i,
  input  logic [DW-1:0]    hwdata_i,
  output logic             hreadyout_o,
  output logic             hresp_o,
  output logic [DW-1:0]    hrdata_o,
  output logic             tl_a_valid_o,
  input  logic             tl_a_ready_i,
  output logic [2:0]       tl_a_opcode_o,
  output logic [2:0]       tl_a_param_o,
  output logic [SZW-1:0]   tl_a_size_o,
  output logic [SRCW-1:0]  tl_a_source_o,
  output logic [AW-1:0]    tl_a_address_o,
  output logic [DBW-1:0]   tl_a_mask_o,
  output logic [DW-1:0]    tl_a_data_o,
  input  logic             tl_d_valid_i,
  output logic             tl_d_ready_o,
  input  logic [2:0]       tl_d_opcode_i,
  input  logic [SRCW-1:0]  tl_d_source_i,
  input  logic [DW-1:0]    tl_d_data_i,
  input  logic             tl_d_error_i,
  input  logic [SZW-1:0]   tl_d_size_i,
  input  logic [SINKW-1:0] tl_d_sink_i,
  output logic             posted_err_o
);

  localparam int unsigned OFFW = $clog2(DBW);

  logic [ST_W-1:0] state_q, state_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic [DW-1:0]   hrdata_q, hrdata_d;
  logic            a_valid_q, a_valid_d;
  logic            d_ready_q, d_ready_d;
  logic            posted_err_q, posted_err_d;
  logic            pending_q, pending_d;
  logic            write_q, write_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [SZW-1:0]  size_q, size_d;
  logic [SRCW-1:0] source_q, source_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DBW-1:0]  mask_q, mask_d;

  logic            accept_c, legal_c, size_ok_c, aligned_c, a_hs_c, d_hs_c;
  logic [DBW-1:0]  mask_c;
  logic            unused_c;

  ahb_tl_mask_gen #(.DBW(DBW)) u_mask_gen (
    .size_i    (hsize_i),
    .offset_i  (haddr_i[OFFW-1:0]),
    .mask_o    (mask_c),
    .size_ok_o (size_ok_c),
    .aligned_o (aligned_c)
  );

  assign accept_c = hsel_i & htrans_i[1] & hready_i;
  assign legal_c  = size_ok_c & aligned_c;
  assign a_hs_c   = a_valid_q & tl_a_ready_i;
  assign d_hs_c   = d_ready_q & tl_d_valid_i;
  // D-channel opcode/size/sink carry nothing the bridge acts on
  assign unused_c = ^{tl_d_opcode_i, tl_d_size_i, tl_d_sink_i, htrans_i[0]};

  // Next-state, latched request fields and next registered outputs
  always_comb begin
    state_d      = state_q;
    hrdata_d     = hrdata_q;
    pending_d    = pending_q;
    posted_err_d = 1'b0;
    write_d      = write_q;
    opcode_d     = opcode_q;
    size_d       = size_q;
    source_d     = source_q;
    addr_d       = addr_q;
    mask_d       = mask_q;

    // Retire an outstanding posted write whenever its ack shows up
    if (pending_q && d_hs_c) begin
      pending_d    = 1'b0;
      posted_err_d = tl_d_error_i;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (legal_c) begin
            state_d  = ST_REQ;
            write_d  = hwrite_i;
            size_d   = SZW'(hsize_i);
            source_d = SRCW'(hmaster_i);
            addr_d   = haddr_i;
            mask_d   = mask_c;
            if (!hwrite_i)                       opcode_d = TL_GET;
            else if (32'(hsize_i) == OFFW)       opcode_d = TL_PUT_FULL;
            else                                 opcode_d = TL_PUT_PARTIAL;
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
      ST_REQ: begin
        if (a_hs_c) begin
          if (POSTED_WR && write_q) begin
            state_d   = ST_IDLE;
            pending_d = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (d_hs_c) begin
          if (!write_q) hrdata_d = tl_d_data_i;
          state_d = (tl_d_error_i || (tl_d_source_i != source_q)) ? ST_ERR1 : ST_DONE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    a_valid_d   = (state_d == ST_REQ) && !pending_d;
    d_ready_d   = (state_d == ST_RESP) || pending_d;
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      hreadyout_q  <= 1'b1;
      hresp_q      <= HRESP_OKAY;
      hrdata_q     <= '0;
      a_valid_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      posted_err_q <= 1'b0;
      pending_q    <= 1'b0;
      write_q      <= 1'b0;
      opcode_q     <= TL_GET;
      size_q       <= '0;
      source_q     <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
      a_valid_q    <= a_valid_d;
      d_ready_q    <= d_ready_d;
      posted_err_q <= posted_err_d;
      pending_q    <= pending_d;
      write_q      <= write_d;
      opcode_q     <= opcode_d;
      size_q       <= size_d;
      source_q     <= source_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
    end
  end

  assign hreadyout_o    = hreadyout_q;
  assign hresp_o        = hresp_q;
  assign hrdata_o       = hrdata_q;
  assign tl_a_valid_o   = a_valid_q;
  assign tl_a_opcode_o  = opcode_q;
  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = size_q;
  assign tl_a_source_o  = source_q;
  assign tl_a_address_o = addr_q;
  assign tl_a_mask_o    = mask_q;
  // Write data is only valid in the AHB data phase, so it is forwarded as-is
  assign tl_a_data_o    = hwdata_i;
  assign tl_d_ready_o   = d_ready_q;
  assign posted_err_o   = posted_err_q;

endmodule

// File: tb/tb_ahb_tl_bridge_param.sv
// Directed bench: 32-bit non-posted and 64-bit posted bridge instances.
module tb_ahb_tl_bridge_param;

  logic        clk;
  logic        rst_n;
  logic        hsel32, hsel64;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [7:0]  hmaster;
  logic [63:0] hwdata;
  logic        a_ready, d_valid, d_error;
  logic [7:0]  d_source;
  logic [63:0] d_data;

  logic        u32_hready, u32_hresp, u32_avalid, u32_dready, u32_perr;
  logic [31:0] u32_hrdata, u32_aaddr, u32_adata;
  logic [2:0]  u32_aop, u32_aparam;
  logic [1:0]  u32_asize;
  logic [7:0]  u32_asrc;
  logic [3:0]  u32_amask;

  logic        u64_hready, u64_hresp, u64_avalid, u64_dready, u64_perr;
  logic [63:0] u64_hrdata, u64_adata;
  logic [31:0] u64_aaddr;
  logic [2:0]  u64_aop, u64_aparam;
  logic [1:0]  u64_asize;
  logic [7:0]  u64_asrc;
  logic [7:0]  u64_amask;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_tl_bridge_param #(.DW(32), .POSTED_WR(1'b0)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .hsel_i(hsel32), .hready_i(u32_hready), .htrans_i(htrans),
    .haddr_i(haddr), .hwrite_i(hwrite), .hsize_i(hsize), .hmaster_i(hmaster), .hwdata_i(hwdata[31:0]),
    .hreadyout_o(u32_hready), .hresp_o(u32_hresp), .hrdata_o(u32_hrdata),
    .tl_a_valid_o(u32_avalid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(u32_aop), .tl_a_param_o(u32_aparam),
    .tl_a_size_o(u32_asize), .tl_a_source_o(u32_asrc), .tl_a_address_o(u32_aaddr), .tl_a_mask_o(u32_amask),
    .tl_a_data_o(u32_adata), .tl_d_valid_i(d_valid), .tl_d_ready_o(u32_dready), .tl_d_opcode_i(3'd1),
    .tl_d_source_i(d_source), .tl_d_data_i(d_data[31:0]), .tl_d_error_i(d_error), .tl_d_size_i(2'd2),
    .tl_d_sink_i(1'b0), .posted_err_o(u32_perr)
  );

  ahb_tl_bridge_param #(.DW(64), .POSTED_WR(1'b1)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .hsel_i(hsel64), .hready_i(u64_hready), .htrans_i(htrans),
    .haddr_i(haddr), .hwrite_i(hwrite), .hsize_i(hsize), .hmaster_i(hmaster), .hwdata_i(hwdata),
    .hreadyout_o(u64_hready), .hresp_o(u64_hresp), .hrdata_o(u64_hrdata),
    .tl_a_valid_o(u64_avalid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(u64_aop), .tl_a_param_o(u64_aparam),
    .tl_a_size_o(u64_asize), .tl_a_source_o(u64_asrc), .tl_a_address_o(u64_aaddr), .tl_a_mask_o(u64_amask),
    .tl_a_data_o(u64_adata), .tl_d_valid_i(d_valid), .tl_d_ready_o(u64_dready), .tl_d_opcode_i(3'd0),
    .tl_d_source_i(d_source), .tl_d_data_i(d_data), .tl_d_error_i(d_error), .tl_d_size_i(2'd0),
    .tl_d_sink_i(1'b0), .posted_err_o(u64_perr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One NONSEQ address phase; returns one cycle later in the data phase
  task automatic addr_phase(input bit sel64, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel32 = !sel64;
    hsel64 = sel64;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    tick();
    hsel32 = 1'b0;
    hsel64 = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic a_accept();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic d_beat(input logic [63:0] data, input logic err);
    d_valid = 1'b1;
    d_data  = data;
    d_error = err;
    tick();
    d_valid = 1'b0;
    d_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hsel32 = 1'b0; hsel64 = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'd0; hmaster = 8'h5A; hwdata = '0; a_ready = 1'b0; d_valid = 1'b0; d_error = 1'b0;
    d_source = 8'h5A; d_data = '0;
    tick(); tick();

    check_eq("rst_hready", 64'(u32_hready), 64'd1);
    check_eq("rst_hresp", 64'(u32_hresp), 64'd0);
    check_eq("rst_hrdata", 64'(u32_hrdata), 64'd0);
    check_eq("rst_avalid", 64'(u32_avalid), 64'd0);
    check_eq("rst_dready", 64'(u32_dready), 64'd0);
    check_eq("rst_perr64", 64'(u64_perr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Word read with delayed response
    addr_phase(1'b0, 32'h100, 1'b0, 3'd2);
    check_eq("rd_hready_wait", 64'(u32_hready), 64'd0);
    check_eq("rd_avalid", 64'(u32_avalid), 64'd1);
    check_eq("rd_opcode", 64'(u32_aop), 64'd4);
    check_eq("rd_size", 64'(u32_asize), 64'd2);
    check_eq("rd_mask", 64'(u32_amask), 64'hF);
    check_eq("rd_addr", 64'(u32_aaddr), 64'h100);
    check_eq("rd_source", 64'(u32_asrc), 64'h5A);
    check_eq("rd_param", 64'(u32_aparam), 64'd0);
    a_accept();
    check_eq("rd_resp_avalid", 64'(u32_avalid), 64'd0);
    check_eq("rd_resp_dready", 64'(u32_dready), 64'd1);
    tick(); tick();
    check_eq("rd_resp_hready", 64'(u32_hready), 64'd0);
    d_beat(64'hCAFEF00D, 1'b0);
    check_eq("rd_done_hready", 64'(u32_hready), 64'd1);
    check_eq("rd_done_hresp", 64'(u32_hresp), 64'd0);
    check_eq("rd_hrdata", 64'(u32_hrdata), 64'hCAFEF00D);
    check_eq("rd_done_dready", 64'(u32_dready), 64'd0);
    tick();

    // Full-word write leaves read data alone
    addr_phase(1'b0, 32'h200, 1'b1, 3'd2);
    hwdata = 64'hDEADBEEF;
    check_eq("wr_opcode", 64'(u32_aop), 64'd0);
    check_eq("wr_mask", 64'(u32_amask), 64'hF);
    check_eq("wr_adata", 64'(u32_adata), 64'hDEADBEEF);
    a_accept();
    d_beat(64'h0, 1'b0);
    check_eq("wr_done_hready", 64'(u32_hready), 64'd1);
    check_eq("wr_hrdata_kept", 64'(u32_hrdata), 64'hCAFEF00D);
    tick();

    // Misaligned halfword: two-cycle ERROR, no TL request
    addr_phase(1'b0, 32'h101, 1'b0, 3'd1);
    check_eq("mis_err1_hready", 64'(u32_hready), 64'd0);
    check_eq("mis_err1_hresp", 64'(u32_hresp), 64'd1);
    check_eq("mis_err1_avalid", 64'(u32_avalid), 64'd0);
    tick();
    check_eq("mis_err2_hready", 64'(u32_hready), 64'd1);
    check_eq("mis_err2_hresp", 64'(u32_hresp), 64'd1);
    check_eq("mis_err2_avalid", 64'(u32_avalid), 64'd0);
    tick();
    check_eq("mis_idle_hresp", 64'(u32_hresp), 64'd0);

    // Oversized transfer on a 32-bit bus
    addr_phase(1'b0, 32'h100, 1'b0, 3'd3);
    check_eq("big_hresp", 64'(u32_hresp), 64'd1);
    check_eq("big_avalid", 64'(u32_avalid), 64'd0);
    tick(); tick();

    // TL error on read, then a transfer accepted from the ERR2 cycle
    addr_phase(1'b0, 32'h300, 1'b0, 3'd2);
    a_accept();
    d_beat(64'h0BAD, 1'b1);
    check_eq("derr_err1_hready", 64'(u32_hready), 64'd0);
    check_eq("derr_err1_hresp", 64'(u32_hresp), 64'd1);
    tick();
    check_eq("derr_err2_hready", 64'(u32_hready), 64'd1);
    check_eq("derr_err2_hresp", 64'(u32_hresp), 64'd1);
    addr_phase(1'b0, 32'h304, 1'b0, 3'd2);
    check_eq("after_err_avalid", 64'(u32_avalid), 64'd1);
    check_eq("after_err_addr", 64'(u32_aaddr), 64'h304);
    check_eq("after_err_hresp", 64'(u32_hresp), 64'd0);
    a_accept();
    d_beat(64'h12345678, 1'b0);
    check_eq("after_err_hrdata", 64'(u32_hrdata), 64'h12345678);
    check_eq("after_err_done_hresp", 64'(u32_hresp), 64'd0);
    tick();

    // Response with the wrong source id is an error
    addr_phase(1'b0, 32'h308, 1'b0, 3'd2);
    a_accept();
    d_source = 8'h11;
    d_beat(64'h0, 1'b0);
    d_source = 8'h5A;
    check_eq("src_mis_hresp", 64'(u32_hresp), 64'd1);
    check_eq("src_mis_hready", 64'(u32_hready), 64'd0);
    tick(); tick();

    // 64-bit posted byte write to lane 5
    addr_phase(1'b1, 32'h2005, 1'b1, 3'd0);
    hwdata = 64'h0000_AB00_0000_0000;
    check_eq("pw_avalid", 64'(u64_avalid), 64'd1);
    check_eq("pw_opcode", 64'(u64_aop), 64'd1);
    check_eq("pw_size", 64'(u64_asize), 64'd0);
    check_eq("pw_mask", 64'(u64_amask), 64'h20);
    check_eq("pw_adata", u64_adata, 64'h0000_AB00_0000_0000);
    check_eq("pw_hready_wait", 64'(u64_hready), 64'd0);
    a_accept();
    check_eq("pw_posted_hready", 64'(u64_hready), 64'd1);
    check_eq("pw_pending_dready", 64'(u64_dready), 64'd1);
    check_eq("pw_posted_avalid", 64'(u64_avalid), 64'd0);

    // Back-to-back full write stalls until the ack arrives
    addr_phase(1'b1, 32'h2008, 1'b1, 3'd3);
    hwdata = 64'h1122_3344_5566_7788;
    check_eq("b2b_stall_avalid", 64'(u64_avalid), 64'd0);
    check_eq("b2b_stall_hready", 64'(u64_hready), 64'd0);
    check_eq("b2b_opcode", 64'(u64_aop), 64'd0);
    check_eq("b2b_mask", 64'(u64_amask), 64'hFF);
    tick();
    check_eq("b2b_still_stalled", 64'(u64_avalid), 64'd0);
    d_beat(64'h0, 1'b1);
    check_eq("b2b_perr_pulse", 64'(u64_perr), 64'd1);
    check_eq("b2b_avalid_go", 64'(u64_avalid), 64'd1);
    check_eq("b2b_dready_clr", 64'(u64_dready), 64'd0);
    a_accept();
    check_eq("b2b_perr_clr", 64'(u64_perr), 64'd0);
    check_eq("b2b_hready", 64'(u64_hready), 64'd1);
    check_eq("b2b_pending", 64'(u64_dready), 64'd1);
    d_beat(64'h0, 1'b0);
    check_eq("b2b_ok_perr", 64'(u64_perr), 64'd0);
    check_eq("b2b_ok_dready", 64'(u64_dready), 64'd0);
    tick();

    // Reset in RESP, then a stale response must not be taken
    addr_phase(1'b0, 32'h400, 1'b0, 3'd2);
    a_accept();
    check_eq("rr_resp_dready", 64'(u32_dready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rr_hready", 64'(u32_hready), 64'd1);
    check_eq("rr_hresp", 64'(u32_hresp), 64'd0);
    check_eq("rr_dready", 64'(u32_dready), 64'd0);
    check_eq("rr_hrdata", 64'(u32_hrdata), 64'd0);
    check_eq("rr_avalid", 64'(u32_avalid), 64'd0);
    tick();
    rst_n = 1'b1;
    d_valid = 1'b1;
    d_data = 64'h5555_AAAA;
    tick();
    check_eq("stale_dready", 64'(u32_dready), 64'd0);
    check_eq("stale_hrdata", 64'(u32_hrdata), 64'd0);
    tick();
    check_eq("stale_hready", 64'(u32_hready), 64'd1);
    d_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
